bus_disk_write: RTL and testbench



---
 rtl/bus_disk_write_if.sv | 25 ++
 rtl/bus_disk_write.sv | 200 ++++++++++++++++++++
 tb/tb_bus_disk_write.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_disk_write_if.sv
// Drive-bus write pins plus the SDRAM buswrite port of bus_disk_write.
// slave = the deserializer, master = whatever drives the bus and consumes writes.
interface bus_disk_write_if;
  logic        BUS_WR_GATE_L;
  logic        BUS_WR_DATA_CLK_L;
  logic        Selected_Ready;
  logic        clkenbl_sector;
  logic        load_address_buswrite;
  logic        dram_write_enbl_buswrite;
  logic [15:0] dram_writedata_buswrite;
  logic        write_indicator;
  logic        write_overrun;

  modport slave (
    input  BUS_WR_GATE_L, BUS_WR_DATA_CLK_L, Selected_Ready, clkenbl_sector,
    output load_address_buswrite, dram_write_enbl_buswrite, dram_writedata_buswrite,
    output write_indicator, write_overrun
  );

  modport master (
    output BUS_WR_GATE_L, BUS_WR_DATA_CLK_L, Selected_Ready, clkenbl_sector,
    input  load_address_buswrite, dram_write_enbl_buswrite, dram_writedata_buswrite,
    input  write_indicator, write_overrun
  );
endinterface

// File: rtl/bus_disk_write.sv
// Deserializes the bus clock+data write stream into 16-bit SDRAM words while
// write gate is active, one strobe per word, partial words flushed at the end.
module bus_disk_write #(
  parameter int DATA_WINDOW      = 41,
  parameter int LOST_CLK         = 100,
  parameter int WORDS_PER_SECTOR = 321
) (
  input logic             clock,
  input logic             reset,
  bus_disk_write_if.slave bus
);
  // state    | meaning
  // IDLE     | waiting for gate to rise
  // PREAMBLE | discarding 0 cells until the sync 1
  // DATA     | shifting bits MSB first, write on every 16th
  // FLUSH    | write any partial word, then back to IDLE
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, FLUSH} state_t;

  localparam int WIN_W  = $clog2(DATA_WINDOW);
  localparam int LOST_W = $clog2(LOST_CLK);
  localparam int WC_W   = $clog2(WORDS_PER_SECTOR + 1);
  localparam logic [WIN_W-1:0]  WIN_LOAD  = WIN_W'(DATA_WINDOW - 1);
  localparam logic [LOST_W-1:0] LOST_LOAD = LOST_W'(LOST_CLK - 1);
  localparam logic [WC_W-1:0]   WC_MAX    = WC_W'(WORDS_PER_SECTOR);

  state_t            state_q, state_d;
  logic              gate_s1_q, gate_s1_d, gate_s2_q, gate_s2_d, gate_prev_q, gate_prev_d;
  logic              dclk_s1_q, dclk_s1_d, dclk_s2_q, dclk_s2_d, dclk_s3_q, dclk_s3_d;
  logic              have_clk_q, have_clk_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [LOST_W-1:0] lost_q, lost_d;
  logic [15:0]       shift_q, shift_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic              load_q, load_d, stb_q, stb_d, ind_q, ind_d, over_q, over_d;
  logic [15:0]       data_q, data_d;

  logic        gate, pulse, active, bit_valid, bit_val, lost_out, exit_req, word_done;
  logic [15:0] word;
  logic [4:0]  pad;

  always_comb begin
    state_d     = state_q;
    gate_s1_d   = bus.BUS_WR_GATE_L;
    gate_s2_d   = gate_s1_q;
    dclk_s1_d   = bus.BUS_WR_DATA_CLK_L;
    dclk_s2_d   = dclk_s1_q;
    dclk_s3_d   = dclk_s2_q;
    have_clk_d  = have_clk_q;
    win_d       = win_q;
    lost_d      = lost_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    load_d      = 1'b0;
    stb_d       = 1'b0;
    over_d      = over_q;
    data_d      = data_q;
    bit_valid   = 1'b0;
    bit_val     = 1'b0;
    lost_out    = 1'b0;
    word_done   = 1'b0;
    word        = 16'h0000;
    pad         = 5'd16 - {1'b0, bit_cnt_q};

    gate        = ~gate_s2_q & bus.Selected_Ready;
    gate_prev_d = gate;
    pulse       = dclk_s3_q & ~dclk_s2_q;
    active      = (state_q == PREAMBLE) || (state_q == DATA);

    // Window timer: after a clock pulse, a pulse before expiry is a 1, expiry is a 0.
    // A pulse landing exactly on expiry resolves a 0 and opens the next cell.
    if (active) begin
      if (have_clk_q) begin
        if (pulse && win_q != '0) begin
          bit_valid  = 1'b1;
          bit_val    = 1'b1;
          have_clk_d = 1'b0;
        end else if (win_q == '0) begin
          bit_valid  = 1'b1;
          have_clk_d = pulse;
          win_d      = WIN_LOAD;
        end else begin
          win_d = win_q - 1'b1;
        end
      end else if (pulse) begin
        have_clk_d = 1'b1;
        win_d      = WIN_LOAD;
      end

      if (pulse) lost_d = LOST_LOAD;
      else if (lost_q != '0) lost_d = lost_q - 1'b1;
      else lost_out = 1'b1;
    end else begin
      have_clk_d = 1'b0;
      win_d      = '0;
    end

    exit_req = ~gate | lost_out | bus.clkenbl_sector;

    case (state_q)
      IDLE: begin
        if (gate && !gate_prev_q) begin
          load_d     = 1'b1;
          word_cnt_d = '0;
          over_d     = 1'b0;
          bit_cnt_d  = '0;
          shift_d    = '0;
          lost_d     = LOST_LOAD;
          state_d    = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (bit_valid && bit_val) state_d = DATA;
        if (exit_req) state_d = FLUSH;
      end
      DATA: begin
        // A bit resolving together with an exit is still counted before FLUSH.
        if (bit_valid) begin
          shift_d   = {shift_q[14:0], bit_val};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd15) begin
            word_done = 1'b1;
            word      = {shift_q[14:0], bit_val};
          end
        end
        if (exit_req) state_d = FLUSH;
      end
      FLUSH: begin
        if (bit_cnt_q != '0) begin
          word_done = 1'b1;
          word      = shift_q << pad;
        end
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (word_done) begin
      if (word_cnt_q != WC_MAX) begin
        stb_d      = 1'b1;
        data_d     = word;
        word_cnt_d = word_cnt_q + 1'b1;
      end else begin
        over_d = 1'b1;
      end
    end

    ind_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      gate_s1_q   <= 1'b1;
      gate_s2_q   <= 1'b1;
      gate_prev_q <= 1'b0;
      dclk_s1_q   <= 1'b1;
      dclk_s2_q   <= 1'b1;
      dclk_s3_q   <= 1'b1;
      have_clk_q  <= 1'b0;
      win_q       <= '0;
      lost_q      <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      load_q      <= 1'b0;
      stb_q       <= 1'b0;
      ind_q       <= 1'b0;
      over_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      gate_s1_q   <= gate_s1_d;
      gate_s2_q   <= gate_s2_d;
      gate_prev_q <= gate_prev_d;
      dclk_s1_q   <= dclk_s1_d;
      dclk_s2_q   <= dclk_s2_d;
      dclk_s3_q   <= dclk_s3_d;
      have_clk_q  <= have_clk_d;
      win_q       <= win_d;
      lost_q      <= lost_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      load_q      <= load_d;
      stb_q       <= stb_d;
      ind_q       <= ind_d;
      over_q      <= over_d;
      data_q      <= data_d;
    end
  end

  assign bus.load_address_buswrite    = load_q;
  assign bus.dram_write_enbl_buswrite = stb_q;
  assign bus.dram_writedata_buswrite  = data_q;
  assign bus.write_indicator          = ind_q;
  assign bus.write_overrun            = over_q;
endmodule

// File: tb/tb_bus_disk_write.sv
// Self-checking bench for bus_disk_write: drives encoded write streams and
// compares the captured SDRAM writes against a word-packing reference model.
module tb_bus_disk_write;
  localparam int WPS = 321;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  bus_disk_write_if bus();

  bus_disk_write dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // Monitor: everything observed on the SDRAM side, accumulated for the tests.
  logic [15:0] cap_q[$];
  int   load_cnt = 0;
  int   b2b_cnt = 0;
  int   ind_drop_cnt = 0;
  int   ind_hi_cnt = 0;
  logic prev_stb = 1'b0;
  logic expect_active = 1'b0;

  always @(negedge clock) begin
    if (bus.dram_write_enbl_buswrite) begin
      cap_q.push_back(bus.dram_writedata_buswrite);
      if (prev_stb) b2b_cnt++;
    end
    prev_stb = bus.dram_write_enbl_buswrite;
    if (bus.load_address_buswrite) load_cnt++;
    if (bus.write_indicator) ind_hi_cnt++;
    if (expect_active && !bus.write_indicator) ind_drop_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Reference model: bits after the sync bit -> words written and overrun flag.
  logic        ref_bits[$];
  logic [15:0] exp_words[$];
  logic        exp_over;

  function automatic void model();
    int acc = 0;
    int n = 0;
    int total = 0;
    exp_words.delete();
    exp_over = 1'b0;
    foreach (ref_bits[i]) begin
      acc = acc * 2 + int'(ref_bits[i]);
      n++;
      if (n == 16) begin
        total++;
        if (total <= WPS) exp_words.push_back(16'(acc));
        else exp_over = 1'b1;
        acc = 0;
        n = 0;
      end
    end
    if (n > 0) begin
      acc = acc * (2 ** (16 - n));
      total++;
      if (total <= WPS) exp_words.push_back(16'(acc));
      else exp_over = 1'b1;
    end
  endfunction

  function automatic void push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) ref_bits.push_back(w[i]);
  endfunction

  function automatic void push_random_bits(input int n);
    for (int i = 0; i < n; i++) ref_bits.push_back(logic'($urandom_range(0, 1)));
  endfunction

  // One bit cell: clock pulse, optional data pulse. Fast cells shorten 1s only.
  task automatic send_cell(input logic b, input logic fast);
    if (b && fast) begin
      bus.BUS_WR_DATA_CLK_L = 1'b0; repeat (2) @(negedge clock);
      bus.BUS_WR_DATA_CLK_L = 1'b1; repeat (2) @(negedge clock);
      bus.BUS_WR_DATA_CLK_L = 1'b0; repeat (2) @(negedge clock);
      bus.BUS_WR_DATA_CLK_L = 1'b1; repeat (2) @(negedge clock);
    end else begin
      bus.BUS_WR_DATA_CLK_L = 1'b0; repeat (3) @(negedge clock);
      bus.BUS_WR_DATA_CLK_L = 1'b1; repeat (24) @(negedge clock);
      bus.BUS_WR_DATA_CLK_L = ~b;   repeat (3) @(negedge clock);
      bus.BUS_WR_DATA_CLK_L = 1'b1; repeat (25) @(negedge clock);
    end
  endtask

  task automatic send_range(input int lo, input int hi, input logic fast);
    for (int i = lo; i < hi; i++) send_cell(ref_bits[i], fast);
  endtask

  task automatic start_write(input int n_zero);
    bus.BUS_WR_GATE_L = 1'b0;
    repeat (6) @(negedge clock);
    expect_active = 1'b1;
    for (int i = 0; i < n_zero; i++) send_cell(1'b0, 1'b0);
    send_cell(1'b1, 1'b0);
  endtask

  task automatic end_write();
    expect_active = 1'b0;
    bus.BUS_WR_GATE_L = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (bus.load_address_buswrite !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", bus.load_address_buswrite); end
    checks++; if (bus.dram_write_enbl_buswrite !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", bus.dram_write_enbl_buswrite); end
    checks++; if (bus.dram_writedata_buswrite !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", bus.dram_writedata_buswrite); end
    checks++; if (bus.write_indicator !== 1'b0) begin errors++; $display("FAIL reset_indicator: got %b expected 0", bus.write_indicator); end
    checks++; if (bus.write_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.write_overrun); end
    reset = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_basic();
    int cb = cap_q.size();
    int lb = load_cnt;
    int bb = b2b_cnt;
    int db = ind_drop_cnt;
    ref_bits.delete();
    push_word(16'hA5C3);
    push_word(16'h0001);
    model();
    start_write(8);
    send_range(0, ref_bits.size(), 1'b0);
    end_write();
    checks++; if (load_cnt - lb !== 1) begin errors++; $display("FAIL basic_load_count: got %0d expected 1", load_cnt - lb); end
    checks++; if (cap_q.size() - cb !== exp_words.size()) begin errors++; $display("FAIL basic_strobe_count: got %0d expected %0d", cap_q.size() - cb, exp_words.size()); end
    foreach (exp_words[i]) if (cb + i < cap_q.size()) begin
      checks++; if (cap_q[cb + i] !== exp_words[i]) begin errors++; $display("FAIL basic_data[%0d]: got %h expected %h", i, cap_q[cb + i], exp_words[i]); end
    end
    checks++; if (ind_drop_cnt - db !== 0) begin errors++; $display("FAIL basic_indicator: low for %0d cycles, expected 0", ind_drop_cnt - db); end
    checks++; if (bus.write_overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b expected 0", bus.write_overrun); end
    checks++; if (b2b_cnt - bb !== 0) begin errors++; $display("FAIL basic_back_to_back: got %0d expected 0", b2b_cnt - bb); end
    checks++; if (bus.write_indicator !== 1'b0) begin errors++; $display("FAIL basic_idle_indicator: got %b expected 0", bus.write_indicator); end
  endtask

  task automatic test_partial_flush();
    int cb = cap_q.size();
    ref_bits.delete();
    push_word(16'hFFFF);
    ref_bits.push_back(1'b1); ref_bits.push_back(1'b0);
    ref_bits.push_back(1'b1); ref_bits.push_back(1'b0);
    model();
    start_write(2);
    send_range(0, ref_bits.size(), 1'b0);
    end_write();
    checks++; if (cap_q.size() - cb !== exp_words.size()) begin errors++; $display("FAIL partial_count: got %0d expected %0d", cap_q.size() - cb, exp_words.size()); end
    foreach (exp_words[i]) if (cb + i < cap_q.size()) begin
      checks++; if (cap_q[cb + i] !== exp_words[i]) begin errors++; $display("FAIL partial_data[%0d]: got %h expected %h", i, cap_q[cb + i], exp_words[i]); end
    end
  endtask

  task automatic test_random_stream();
    int cb = cap_q.size();
    int bb = b2b_cnt;
    ref_bits.delete();
    push_random_bits(16 * 3 + $urandom_range(1, 15));
    model();
    start_write($urandom_range(0, 4));
    send_range(0, ref_bits.size(), 1'b1);
    end_write();
    checks++; if (cap_q.size() - cb !== exp_words.size()) begin errors++; $display("FAIL random_count: got %0d expected %0d", cap_q.size() - cb, exp_words.size()); end
    foreach (exp_words[i]) if (cb + i < cap_q.size()) begin
      checks++; if (cap_q[cb + i] !== exp_words[i]) begin errors++; $display("FAIL random_data[%0d]: got %h expected %h", i, cap_q[cb + i], exp_words[i]); end
    end
    checks++; if (b2b_cnt - bb !== 0) begin errors++; $display("FAIL random_back_to_back: got %0d expected 0", b2b_cnt - bb); end
  endtask

  task automatic test_overrun();
    int cb = cap_q.size();
    int lb;
    int bad = 0;
    ref_bits.delete();
    for (int i = 0; i < WPS - 1; i++) push_word(16'hFFFF);
    push_word(16'h1234);
    push_word(16'h1234);
    model();
    start_write(1);
    send_range(0, 16 * WPS, 1'b1);
    checks++; if (bus.write_overrun !== 1'b0) begin errors++; $display("FAIL overrun_at_limit: got %b expected 0", bus.write_overrun); end
    send_range(16 * WPS, ref_bits.size(), 1'b1);
    checks++; if (bus.write_overrun !== exp_over) begin errors++; $display("FAIL overrun_set: got %b expected %b", bus.write_overrun, exp_over); end
    end_write();
    checks++; if (cap_q.size() - cb !== exp_words.size()) begin errors++; $display("FAIL overrun_count: got %0d expected %0d", cap_q.size() - cb, exp_words.size()); end
    foreach (exp_words[i]) if (cb + i < cap_q.size() && cap_q[cb + i] !== exp_words[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL overrun_data: %0d words differ, expected 0", bad); end
    checks++; if (bus.write_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", bus.write_overrun); end
    lb = load_cnt;
    bus.BUS_WR_GATE_L = 1'b0;
    repeat (6) @(negedge clock);
    checks++; if (bus.write_overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", bus.write_overrun); end
    checks++; if (load_cnt - lb !== 1) begin errors++; $display("FAIL overrun_reload: got %0d expected 1", load_cnt - lb); end
    repeat (110) @(negedge clock);
    bus.BUS_WR_GATE_L = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic test_not_selected();
    int cb = cap_q.size();
    int lb = load_cnt;
    int hb = ind_hi_cnt;
    bus.Selected_Ready = 1'b0;
    bus.BUS_WR_GATE_L = 1'b0;
    repeat (6) @(negedge clock);
    send_cell(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) send_cell(logic'($urandom_range(0, 1)), 1'b0);
    bus.BUS_WR_GATE_L = 1'b1;
    repeat (5) @(negedge clock);
    bus.Selected_Ready = 1'b1;
    repeat (5) @(negedge clock);
    checks++; if (load_cnt - lb !== 0) begin errors++; $display("FAIL nosel_load: got %0d expected 0", load_cnt - lb); end
    checks++; if (cap_q.size() - cb !== 0) begin errors++; $display("FAIL nosel_strobe: got %0d expected 0", cap_q.size() - cb); end
    checks++; if (ind_hi_cnt - hb !== 0) begin errors++; $display("FAIL nosel_indicator: high %0d cycles, expected 0", ind_hi_cnt - hb); end
  endtask

  // mode 0: pulses stop; 1: sector boundary; 2: Selected_Ready drops
  task automatic test_abort(input int mode, input int nbits);
    int cb = cap_q.size();
    ref_bits.delete();
    push_random_bits(nbits);
    model();
    start_write(1);
    send_range(0, ref_bits.size(), 1'b0);
    expect_active = 1'b0;
    if (mode == 0) begin
      repeat (120) @(negedge clock);
    end else if (mode == 1) begin
      bus.clkenbl_sector = 1'b1; @(negedge clock);
      bus.clkenbl_sector = 1'b0; repeat (6) @(negedge clock);
    end else begin
      bus.Selected_Ready = 1'b0; repeat (6) @(negedge clock);
    end
    checks++; if (cap_q.size() - cb !== exp_words.size()) begin errors++; $display("FAIL abort%0d_count: got %0d expected %0d", mode, cap_q.size() - cb, exp_words.size()); end
    foreach (exp_words[i]) if (cb + i < cap_q.size()) begin
      checks++; if (cap_q[cb + i] !== exp_words[i]) begin errors++; $display("FAIL abort%0d_data[%0d]: got %h expected %h", mode, i, cap_q[cb + i], exp_words[i]); end
    end
    checks++; if (bus.write_indicator !== 1'b0) begin errors++; $display("FAIL abort%0d_idle: got %b expected 0", mode, bus.write_indicator); end
    bus.BUS_WR_GATE_L = 1'b1;
    repeat (5) @(negedge clock);
    bus.Selected_Ready = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_reset_midword();
    int cb = cap_q.size();
    start_write(1);
    for (int i = 0; i < 7; i++) send_cell(logic'($urandom_range(0, 1)), 1'b0);
    expect_active = 1'b0;
    bus.BUS_WR_DATA_CLK_L = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if ({bus.load_address_buswrite, bus.dram_write_enbl_buswrite, bus.write_indicator, bus.write_overrun} !== 4'b0000)
      begin errors++; $display("FAIL midreset_outputs: got %b expected 0000", {bus.load_address_buswrite, bus.dram_write_enbl_buswrite, bus.write_indicator, bus.write_overrun}); end
    checks++; if (bus.dram_writedata_buswrite !== 16'h0000) begin errors++; $display("FAIL midreset_data: got %h expected 0000", bus.dram_writedata_buswrite); end
    bus.BUS_WR_GATE_L = 1'b1;
    bus.BUS_WR_DATA_CLK_L = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (60) @(negedge clock);
    checks++; if (cap_q.size() - cb !== 0) begin errors++; $display("FAIL midreset_strobe: got %0d expected 0", cap_q.size() - cb); end
    checks++; if (bus.write_indicator !== 1'b0) begin errors++; $display("FAIL midreset_indicator: got %b expected 0", bus.write_indicator); end
  endtask

  initial begin
    bus.BUS_WR_GATE_L     = 1'b1;
    bus.BUS_WR_DATA_CLK_L = 1'b1;
    bus.Selected_Ready    = 1'b1;
    bus.clkenbl_sector    = 1'b0;
    test_reset();
    test_basic();
    test_partial_flush();
    test_random_stream();
    test_random_stream();
    test_not_selected();
    test_abort(0, 5);
    test_abort(1, 10);
    test_abort(2, 16 + $urandom_range(1, 15));
    test_reset_midword();
    test_overrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
